// File: rtl/meter_pkg.sv
// Shared types and defaults for the clock frequency meter.
//   meter_state_e : measurement FSM state encoding
//   GATE_1S       : one-second gate window at 100 MHz
//   CNT_W_DEF     : default edge counter / result width
package meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } meter_state_e;

  localparam int GATE_1S   = 100_000_000;
  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/sync_edge_det.sv
// Brings an asynchronous pulse train into the fpga_clk domain and emits a
// one-cycle pulse per rising edge. The pulse appears 3 fpga_clk cycles after
// the input edge. Detection is held off until 3 cycles after reset release,
// so an input that is already high at reset does not produce a false edge.
//
// Ports:
//   fpga_clk : system clock
//   rst      : asynchronous active-low reset
//   sig_in   : asynchronous input signal
//   edge_det : one-cycle rising-edge pulse (already qualified by priming)
module sync_edge_det (
  input  logic fpga_clk,
  input  logic rst,
  input  logic sig_in,
  output logic edge_det
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic       primed;
  logic [1:0] prime_cnt;

  always_ff @(posedge fpga_clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      prev      <= 1'b0;
      edge_det  <= 1'b0;
      primed    <= 1'b0;
      prime_cnt <= 2'd0;
    end else begin
      sync1    <= sig_in;
      sync2    <= sync1;
      prev     <= sync2;
      // primed is sampled before it sets, which masks the one spurious
      // sync2 & ~prev pulse seen when sig_in is high coming out of reset.
      edge_det <= primed & sync2 & ~prev;
      if (!primed) begin
        if (prime_cnt == 2'd2) begin
          primed <= 1'b1;
        end else begin
          prime_cnt <= prime_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of a slow asynchronous signal over a gate window of
// GATE_CYCLES fpga_clk cycles and reports the count, a saturation flag and a
// tolerance check against EXP_CNT +/- TOL.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start or continuous
//   MEASURE | gate window running, edges accumulate (GATE_CYCLES cycles)
//   DONE    | one-cycle result publish, valid high, edges not counted
//
// Ports:
//   fpga_clk   : system clock
//   rst        : asynchronous active-low reset
//   sig_in     : signal under measurement (asynchronous)
//   start      : one-cycle request for a single window
//   continuous : repeat windows back-to-back while high
//   freq_cnt   : edge count of the last completed window
//   valid      : one-cycle pulse when results update
//   busy       : high while a window is in progress
//   overflow   : last window's count saturated
//   in_range   : last window's count within EXP_CNT +/- TOL
module clk_freq_meter
  import meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_1S,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int EXP_CNT     = 100,
  parameter int TOL         = 1
) (
  input  logic             fpga_clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             valid,
  output logic             busy,
  output logic             overflow,
  output logic             in_range
);

  localparam int                       GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]            GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]         CNT_MAX   = '1;
  localparam logic signed [CNT_W:0]    EXP_S     = (CNT_W+1)'(EXP_CNT);
  localparam logic signed [CNT_W:0]    TOL_S     = (CNT_W+1)'(TOL);

  meter_state_e        state_q, state_d;
  logic [GW-1:0]       gate_q, gate_d;
  logic [CNT_W-1:0]    edge_q, edge_d;
  logic                sat_q, sat_d;
  logic                load;
  logic                edge_pulse;
  logic signed [CNT_W:0] diff;
  logic signed [CNT_W:0] mag;
  logic                in_tol;

  sync_edge_det u_sync_edge_det (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .edge_det (edge_pulse)
  );

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    edge_d  = edge_q;
    sat_d   = sat_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || continuous) begin
          state_d = MEASURE;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
        end
      end
      MEASURE: begin
        gate_d = gate_q + GW'(1);
        if (edge_pulse && (edge_q != CNT_MAX)) begin
          edge_d = edge_q + CNT_W'(1);
        end
        sat_d = sat_q | (edge_d == CNT_MAX);
        // Results are captured on the way into DONE so that they are
        // already visible in the cycle where valid is high, including any
        // edge that arrived on the final gate cycle.
        if (gate_q == GATE_LAST) begin
          state_d = DONE;
          load    = 1'b1;
        end
      end
      DONE: begin
        if (continuous) begin
          state_d = MEASURE;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One extra bit keeps the signed difference free of wrap-around.
  always_comb begin
    diff   = $signed({1'b0, edge_d}) - EXP_S;
    mag    = diff[CNT_W] ? -diff : diff;
    in_tol = (mag <= TOL_S);
  end

  always_ff @(posedge fpga_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gate_q   <= '0;
      edge_q   <= '0;
      sat_q    <= 1'b0;
      freq_cnt <= '0;
      overflow <= 1'b0;
      in_range <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      sat_q   <= sat_d;
      if (load) begin
        freq_cnt <= edge_d;
        overflow <= sat_d;
        in_range <= in_tol & ~sat_d;
      end
    end
  end

  assign valid = (state_q == DONE);
  assign busy  = (state_q == MEASURE);

endmodule

// File: tb/tb_clk_freq_meter.sv
module tb_clk_freq_meter;

  localparam int G_A = 1000;
  localparam int W_A = 32;
  localparam int E_A = 100;
  localparam int T_A = 1;
  localparam int G_B = 200;
  localparam int W_B = 4;
  localparam int E_B = 10;
  localparam int T_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           sig_a, sig_b;
  logic           start_a, start_b;
  logic           cont_a, cont_b;
  logic [W_A-1:0] freq_a;
  logic [W_B-1:0] freq_b;
  logic           valid_a, valid_b, busy_a, busy_b;
  logic           ovf_a, ovf_b, inr_a, inr_b;

  clk_freq_meter #(.GATE_CYCLES(G_A), .CNT_W(W_A), .EXP_CNT(E_A), .TOL(T_A)) dut_a (
    .fpga_clk(clk), .rst(rst), .sig_in(sig_a), .start(start_a), .continuous(cont_a),
    .freq_cnt(freq_a), .valid(valid_a), .busy(busy_a), .overflow(ovf_a), .in_range(inr_a)
  );

  clk_freq_meter #(.GATE_CYCLES(G_B), .CNT_W(W_B), .EXP_CNT(E_B), .TOL(T_B)) dut_b (
    .fpga_clk(clk), .rst(rst), .sig_in(sig_b), .start(start_b), .continuous(cont_b),
    .freq_cnt(freq_b), .valid(valid_b), .busy(busy_b), .overflow(ovf_b), .in_range(inr_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int     cyc;
    longint freq;
    bit     ovf;
    bit     inr;
  } rec_t;

  rec_t vq_a[$];
  rec_t vq_b[$];
  int   busy_cnt_a = 0;
  int   rises_a[$];
  int   rises_b[$];

  // result monitor
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (valid_a === 1'b1) begin
        r.cyc = cyc; r.freq = longint'(freq_a); r.ovf = ovf_a; r.inr = inr_a;
        vq_a.push_back(r);
      end
      if (valid_b === 1'b1) begin
        r.cyc = cyc; r.freq = longint'(freq_b); r.ovf = ovf_b; r.inr = inr_b;
        vq_b.push_back(r);
      end
      if (busy_a === 1'b1) busy_cnt_a++;
    end
  end

  // stimulus generator: random high/low phase lengths, rise cycles logged
  bit gen_en[2];
  int lo_min[2], lo_max[2], hi_min[2], hi_max[2], left[2];

  initial begin
    logic lvl;
    forever begin
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 2; ch++) begin
        if (gen_en[ch]) begin
          if (left[ch] > 1) begin
            left[ch]--;
          end else begin
            lvl = (ch == 0) ? ~sig_a : ~sig_b;
            if (ch == 0) sig_a = lvl; else sig_b = lvl;
            if (lvl) begin
              if (ch == 0) rises_a.push_back(cyc); else rises_b.push_back(cyc);
              left[ch] = int'($urandom_range(hi_max[ch], hi_min[ch]));
            end else begin
              left[ch] = int'($urandom_range(lo_max[ch], lo_min[ch]));
            end
          end
        end
      end
    end
  end

  task automatic set_gen(input int ch, input int lmin, input int lmax, input int hmin, input int hmax);
    lo_min[ch] = lmin; lo_max[ch] = lmax; hi_min[ch] = hmin; hi_max[ch] = hmax;
    left[ch] = 2;
    gen_en[ch] = 1'b1;
  endtask

  // Reference: a rise logged at cycle k shows up as a counted event in cycle
  // k+3; the window counts events in the G cycles before the valid cycle.
  function automatic longint model_raw(input int ch, input int first, input int last);
    longint n = 0;
    if (ch == 0) begin
      foreach (rises_a[i]) if (rises_a[i] + 3 >= first && rises_a[i] + 3 <= last) n++;
    end else begin
      foreach (rises_b[i]) if (rises_b[i] + 3 >= first && rises_b[i] + 3 <= last) n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wait_valid(input int ch, input int n_total, input int budget);
    int k = 0;
    int sz;
    sz = (ch == 0) ? vq_a.size() : vq_b.size();
    while (sz < n_total && k < budget) begin
      @(negedge clk);
      #1;
      k++;
      sz = (ch == 0) ? vq_a.size() : vq_b.size();
    end
    chk("valid_arrived", longint'(sz >= n_total), 1);
  endtask

  task automatic check_window(input string tag, input int ch, input int idx, input int exp_cyc);
    rec_t   r;
    int     g, e, t;
    longint raw, maxv, ef;
    bit     eo, ei;
    if (ch == 0) begin
      if (idx >= vq_a.size()) return;
      r = vq_a[idx]; g = G_A; e = E_A; t = T_A; maxv = (longint'(1) << W_A) - 1;
    end else begin
      if (idx >= vq_b.size()) return;
      r = vq_b[idx]; g = G_B; e = E_B; t = T_B; maxv = (longint'(1) << W_B) - 1;
    end
    raw = model_raw(ch, r.cyc - g, r.cyc - 1);
    eo  = (raw >= maxv);
    ef  = eo ? maxv : raw;
    ei  = !eo && (raw >= e - t) && (raw <= e + t);
    chk({tag, "_valid_cyc"}, r.cyc, exp_cyc);
    chk({tag, "_freq"}, r.freq, ef);
    chk({tag, "_ovf"}, r.ovf, eo);
    chk({tag, "_inr"}, r.inr, ei);
  endtask

  task automatic pulse_start(input int ch, output int s);
    @(posedge clk);
    #1;
    if (ch == 0) start_a = 1'b1; else start_b = 1'b1;
    s = cyc;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s, s2, c, b0, tgt;
    rst = 1'b0;
    sig_a = 1'b1; sig_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    cont_a = 1'b0; cont_b = 1'b0;
    gen_en[0] = 1'b0; gen_en[1] = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_freq_a", freq_a, 0);
    chk("rst_valid_a", valid_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_inr_a", inr_a, 0);
    chk("rst_freq_b", freq_b, 0);

    // release with sig_in high, start immediately: no spurious edge
    @(posedge clk);
    #1;
    rst = 1'b1;
    pulse_start(0, s);
    wait_valid(0, 1, G_A + 20);
    check_window("const_hi", 0, 0, s + 1 + G_A);
    if (vq_a.size() > 0) chk("const_hi_zero", vq_a[0].freq, 0);

    // period 10 single window
    set_gen(0, 5, 5, 5, 5);
    idle_cycles(30);
    b0 = busy_cnt_a;
    pulse_start(0, s);
    wait_valid(0, 2, G_A + 20);
    check_window("p10", 0, 1, s + 1 + G_A);
    if (vq_a.size() > 1) chk("p10_is_100", vq_a[1].freq, 100);
    chk("p10_busy_cycles", busy_cnt_a - b0, G_A);
    idle_cycles(30);
    chk("p10_one_valid", vq_a.size(), 2);

    // continuous, randomized ~period 20, then drop continuous mid-window
    set_gen(0, 8, 12, 8, 12);
    idle_cycles(10);
    c = cyc;
    cont_a = 1'b1;
    wait_valid(0, 5, 3 * (G_A + 1) + 50);
    for (int k = 0; k < 3; k++) check_window("cont", 0, 2 + k, c + 1 + G_A + k * (G_A + 1));
    if (vq_a.size() > 4) begin
      tgt = vq_a[4].cyc + 300;
      wait_until(tgt);
      cont_a = 1'b0;
      wait_valid(0, 6, G_A + 50);
      check_window("cont_drop", 0, 5, vq_a[4].cyc + 1 + G_A);
    end
    idle_cycles(1100);
    chk("cont_drop_count", vq_a.size(), 6);
    chk("cont_drop_idle", busy_a, 0);

    // narrow counter saturates
    set_gen(1, 2, 2, 2, 2);
    idle_cycles(20);
    pulse_start(1, s);
    wait_valid(1, 1, G_B + 20);
    check_window("sat", 1, 0, s + 1 + G_B);
    if (vq_b.size() > 0) begin
      chk("sat_freq15", vq_b[0].freq, 15);
      chk("sat_ovf", vq_b[0].ovf, 1);
    end

    // narrow counter in range (period 20 -> 10 edges)
    set_gen(1, 10, 10, 10, 10);
    idle_cycles(30);
    pulse_start(1, s);
    wait_valid(1, 2, G_B + 20);
    check_window("b_inr", 1, 1, s + 1 + G_B);
    if (vq_b.size() > 1) chk("b_inr_set", vq_b[1].inr, 1);

    // second start mid-window ignored
    set_gen(0, 3, 7, 3, 7);
    idle_cycles(20);
    pulse_start(0, s);
    wait_until(s + 300);
    pulse_start(0, s2);
    wait_valid(0, 7, G_A + 50);
    check_window("restart", 0, 6, s + 1 + G_A);
    idle_cycles(1200);
    chk("restart_one_valid", vq_a.size(), 7);

    // reset mid-window discards the partial count
    pulse_start(0, s);
    wait_until(s + 500);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy", busy_a, 0);
    chk("abort_freq", freq_a, 0);
    chk("abort_valid", valid_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(1100);
    chk("abort_no_valid", vq_a.size(), 7);
    @(negedge clk);
    chk("abort_freq_held", freq_a, 0);
    pulse_start(0, s);
    wait_valid(0, 8, G_A + 50);
    check_window("post_abort", 0, 7, s + 1 + G_A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_freq_meter.md
Name: clk_freq_meter

Overview:
- Measures the frequency of a slow, asynchronous digital signal by counting its rising edges over a fixed gate window of fpga_clk cycles.
- Intended to check the divided clocks (e.g. the 1 kHz and 100 Hz stepping-motor clock) and external encoder/sensor pulse trains against an expected rate.
- Sits beside the clock-divider top. Its result feeds status registers or LEDs.

Parameters:
- GATE_CYCLES, 100_000_000, length of gate window in fpga_clk cycles (1 s at 100 MHz); must be >= 2.
- CNT_W, 32, width of edge counter and result.
- EXP_CNT, 100, expected edge count per window, used for in_range.
- TOL, 1, allowed absolute deviation from EXP_CNT for in_range.

Ports:
- fpga_clk  input  1  system clock, 100 MHz; the only clock.
- rst  input  1  asynchronous, active-low reset.
- sig_in  input  1  signal under measurement; asynchronous to fpga_clk; high and low phases each >= 2 fpga_clk cycles.
- start  input  1  single-cycle request to run one measurement.
- continuous  input  1  when high, windows repeat back-to-back.
- freq_cnt  output  CNT_W  rising edges counted in the last completed window.
- valid  output  1  one-cycle pulse when freq_cnt/overflow/in_range update.
- busy  output  1  high while a window is in progress.
- overflow  output  1  last window's count saturated.
- in_range  output  1  |freq_cnt - EXP_CNT| <= TOL for the last window.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM in IDLE, all counters 0, synchronizer and edge registers 0, primed = 0.
- Input path:
  - sig_in goes through a 2-flop synchronizer, then a registered rising-edge detect (sync2 & ~prev).
  - Latency: a sig_in edge becomes an edge_det pulse 3 fpga_clk cycles later.
  - A primed bit sets 3 cycles after reset release. edge_det is ignored until then, so no spurious edge occurs if sig_in is high at reset.
- FSM states: IDLE, MEASURE, DONE.
  - IDLE: busy=0. If start=1 or continuous=1, go to MEASURE next cycle and clear gate_cnt and edge_cnt.
  - MEASURE: busy=1. gate_cnt increments every cycle. A qualified edge_det increments edge_cnt. When gate_cnt == GATE_CYCLES-1, go to DONE. An edge on this final cycle is counted. The window is exactly GATE_CYCLES cycles.
  - DONE: busy=0 for exactly one cycle.
    - Registers freq_cnt, overflow and in_range from the final edge_cnt.
    - valid=1 during this cycle only.
    - Next state is MEASURE (counters cleared) if continuous=1, else IDLE.
    - Edges during the DONE cycle are not counted (one-cycle dead time per window).
- start while in MEASURE or DONE is ignored. It is not queued.
- Dropping continuous mid-window: the current window completes normally, then the FSM returns to IDLE.
- Saturation: edge_cnt holds at all-ones once reached, and a sticky sat bit sets. overflow = sat at DONE. When overflow=1, in_range is forced to 0.
- in_range arithmetic: computed at CNT_W+1 bits signed difference. No wrap-around.
- Outputs freq_cnt, overflow and in_range hold their values until the next DONE or reset.
- Reset mid-window discards the partial count. valid does not pulse.

Decomposition:
- Shared package meter_pkg holds:
  - FSM state enum (IDLE=2'd0, MEASURE=2'd1, DONE=2'd2).
  - Default constants: GATE_1S = 100_000_000, CNT_W_DEF = 32.
- One natural sub-module: sync_edge_det (2-flop synchronizer + priming + rising-edge pulse). It is reusable for the stepping-motor and encoder inputs.

Test Plan:
- Reset release with sig_in held high, then start with GATE_CYCLES=1000 and sig_in constant -> valid pulses once at cycle 1000 after MEASURE entry; freq_cnt=0, in_range=0 (EXP_CNT=100, TOL=1).
- GATE_CYCLES=1000, sig_in period 10 cycles, start pulse -> busy high 1000 cycles; valid once; freq_cnt=100, in_range=1, overflow=0.
- continuous=1, sig_in period 20 -> valid every 1001 cycles; each freq_cnt in {49,50,51}; dropping continuous mid-window gives exactly one more valid, then IDLE.
- CNT_W=4, sig_in period 4, GATE_CYCLES=200 -> freq_cnt=15, overflow=1, in_range=0.
- start pulsed again 300 cycles into a window -> no restart; single valid at the original window end; count unaffected.
- rst asserted 500 cycles into a window, released, then start -> no valid from the aborted window; freq_cnt=0 until the new window completes with the correct count.
